// File: rtl/cpu_step_ctrl.sv
// Step/run clock-enable generator for the single-cycle RV32 core.
// Debounces the step button, divides the clock in run mode, freezes on halt.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 50000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_n,
    input  logic             run_sw,
    input  logic             halt,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] step_cnt,
    output logic             halted,
    output logic [1:0]       state
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DVW = $clog2(RUN_DIV);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_REL = 2'b01,
        RUN      = 2'b10,
        HALT     = 2'b11
    } state_t;

    logic             btn_s1_q, btn_s2_q;
    logic             run_s1_q, run_s2_q;
    logic [DBW-1:0]   db_cnt_q, db_cnt_d;
    logic             btn_db_q, btn_db_d;
    logic             press_q, press_d;
    logic [DVW-1:0]   div_q, div_d;
    state_t           state_q, state_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             halted_q, halted_d;

    // Counter only runs while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts it.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
        press_d = btn_db_q & ~btn_db_d;
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cpu_ce_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = HALT;
                end else if (press_q) begin
                    cpu_ce_d = 1'b1;
                    state_d  = WAIT_REL;
                end else if (run_s2_q) begin
                    state_d = RUN;
                    div_d   = '0;
                end
            end
            WAIT_REL: begin
                if (halt) begin
                    state_d = HALT;
                end else if (btn_db_q) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                end else if (!run_s2_q) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    cpu_ce_d = 1'b1;
                    div_d    = '0;
                end else begin
                    div_d = div_q + DVW'(1);
                end
            end
            HALT: begin
                if (press_q && !run_s2_q) begin
                    state_d = WAIT_REL;
                end
            end
            default: state_d = IDLE;
        endcase
        step_cnt_d = step_cnt_q + CNT_W'(cpu_ce_d);
        halted_d   = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b1;
            btn_s2_q   <= 1'b1;
            run_s1_q   <= 1'b0;
            run_s2_q   <= 1'b0;
            db_cnt_q   <= '0;
            btn_db_q   <= 1'b1;
            press_q    <= 1'b0;
            div_q      <= '0;
            state_q    <= IDLE;
            cpu_ce_q   <= 1'b0;
            step_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            btn_s1_q   <= btn_n;
            btn_s2_q   <= btn_s1_q;
            run_s1_q   <= run_sw;
            run_s2_q   <= run_s1_q;
            db_cnt_q   <= db_cnt_d;
            btn_db_q   <= btn_db_d;
            press_q    <= press_d;
            div_q      <= div_d;
            state_q    <= state_d;
            cpu_ce_q   <= cpu_ce_d;
            step_cnt_q <= step_cnt_d;
            halted_q   <= halted_d;
        end
    end

    assign cpu_ce   = cpu_ce_q;
    assign step_cnt = step_cnt_q;
    assign halted   = halted_q;
    assign state    = state_q;

endmodule
